// File: rtl/ap_pkg.sv
// Shared definitions for the AP host-side blocks (loader and result reader).
package ap_pkg;

    // Column select codes on the AP sel_col bus
    localparam logic [1:0] COL_A = 2'd0;
    localparam logic [1:0] COL_B = 2'd1;
    localparam logic [1:0] COL_C = 2'd2;

    // AP operation codes
    localparam logic [2:0] OP_OR   = 3'd0;
    localparam logic [2:0] OP_XOR  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_NOT  = 3'd3;
    localparam logic [2:0] OP_ADD  = 3'd4;
    localparam logic [2:0] OP_SUB  = 3'd5;
    localparam logic [2:0] OP_MULT = 3'd6;

    // Result reader sweep states
    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        PRESENT,
        DONE
    } rd_state_t;

endpackage

// File: rtl/ap_irq_edge_det.sv
// Registered rising-edge detector for a level flag, synchronous active-high reset.
module ap_irq_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);

    logic level_q;

    // Remember last cycle's level; reset forces it low so a high level after reset is an edge
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/ap_result_reader.sv
// Unload engine: on a rising AP completion flag, sweeps one AP column with single
// outstanding reads and streams each word out over valid/ready with index and last flag.
module ap_result_reader
    import ap_pkg::*;
#(
    parameter int unsigned WORD_SIZE    = 8,
    parameter int unsigned CELL_QUANT   = 512,
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                 CLK100MHZ,
    input  logic                 rst,
    input  logic                 arm,
    input  logic                 ap_state_irq,
    input  logic [1:0]           rd_col,
    input  logic                 rd_internal_col,
    input  logic [ADDR_W-1:0]    rd_count,
    output logic [ADDR_W-1:0]    addr,
    output logic [1:0]           sel_col,
    output logic                 sel_internal_col,
    output logic                 read_en,
    output logic                 write_en,
    input  logic [WORD_SIZE-1:0] data_out,
    output logic [WORD_SIZE-1:0] m_data,
    output logic [ADDR_W-1:0]    m_index,
    output logic                 m_last,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun
);

    localparam int unsigned CNT_W = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY + 1);

    rd_state_t              state_q, state_d;
    logic [ADDR_W-1:0]      idx_q, idx_d;
    logic [ADDR_W-1:0]      last_idx_q, last_idx_d;
    logic [1:0]             col_q, col_d;
    logic                   icol_q, icol_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [WORD_SIZE-1:0]   m_data_q, m_data_d;
    logic [ADDR_W-1:0]      m_index_q, m_index_d;
    logic                   m_last_q, m_last_d;
    logic                   overrun_q, overrun_d;

    logic                   irq_rise;
    logic                   trigger;
    logic [ADDR_W-1:0]      req_last;

    ap_irq_edge_det u_irq_edge (
        .clk   (CLK100MHZ),
        .rst   (rst),
        .level (ap_state_irq),
        .rise  (irq_rise)
    );

    assign trigger = irq_rise & arm & (state_q == IDLE);

    // Final index of the sweep: count 0 or anything beyond the column means a full column
    always_comb begin
        if ((rd_count == '0) || (32'(rd_count) > CELL_QUANT)) begin
            req_last = ADDR_W'(CELL_QUANT - 1);
        end else begin
            req_last = rd_count - ADDR_W'(1);
        end
    end

    // Sweep state register and captured result beat
    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            last_idx_q <= '0;
            col_q      <= '0;
            icol_q     <= 1'b0;
            cnt_q      <= '0;
            m_data_q   <= '0;
            m_index_q  <= '0;
            m_last_q   <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            last_idx_q <= last_idx_d;
            col_q      <= col_d;
            icol_q     <= icol_d;
            cnt_q      <= cnt_d;
            m_data_q   <= m_data_d;
            m_index_q  <= m_index_d;
            m_last_q   <= m_last_d;
            overrun_q  <= overrun_d;
        end
    end

    // Next-state logic: one read outstanding, each beat is issue, wait for latency, present
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        last_idx_d = last_idx_q;
        col_d      = col_q;
        icol_d     = icol_q;
        cnt_d      = cnt_q;
        m_data_d   = m_data_q;
        m_index_d  = m_index_q;
        m_last_d   = m_last_q;
        overrun_d  = overrun_q;

        // A completion edge while a sweep owns the bus would be lost; flag it
        if (irq_rise && arm && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (trigger) begin
                    col_d      = rd_col;
                    icol_d     = rd_internal_col;
                    last_idx_d = req_last;
                    idx_d      = '0;
                    overrun_d  = 1'b0;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CNT_W'(READ_LATENCY);
                state_d = WAIT;
            end
            WAIT: begin
                // cnt == 1 marks the cycle in which data_out carries the issued word
                if (cnt_q == CNT_W'(1)) begin
                    m_data_d  = data_out;
                    m_index_d = idx_q;
                    m_last_d  = (idx_q == last_idx_q);
                    state_d   = PRESENT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            PRESENT: begin
                if (m_ready) begin
                    if (m_last_q) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = ISSUE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // AP bus is driven only while a sweep owns it; otherwise parked at zero
    always_comb begin
        busy             = (state_q != IDLE);
        read_en          = (state_q == ISSUE);
        write_en         = 1'b0;
        addr             = busy ? idx_q : '0;
        sel_col          = busy ? col_q : 2'd0;
        sel_internal_col = busy ? icol_q : 1'b0;
        m_valid          = (state_q == PRESENT);
        done             = (state_q == DONE);
        m_data           = m_data_q;
        m_index          = m_index_q;
        m_last           = m_last_q;
        overrun          = overrun_q;
    end

endmodule

// File: tb/tb_ap_result_reader.sv
// Bench for ap_result_reader: scoreboard model of the sweep contract plus directed tests.
module tb_ap_result_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Shared and LAT=1 DUT stimulus
    logic       rst = 1'b1;
    logic       arm = 1'b0;
    logic       irq = 1'b0;
    logic [1:0] rd_col = 2'd0;
    logic       rd_icol = 1'b0;
    logic [9:0] rd_count = 10'd0;
    logic       m_ready = 1'b1;

    logic [9:0] addr, m_index;
    logic [1:0] sel_col;
    logic       sel_icol, read_en, write_en, m_last, m_valid, busy, done, overrun;
    logic [7:0] data_out, m_data;

    ap_result_reader #(.WORD_SIZE(8), .CELL_QUANT(512), .ADDR_W(10), .READ_LATENCY(1)) dut (
        .CLK100MHZ(clk), .rst(rst), .arm(arm), .ap_state_irq(irq), .rd_col(rd_col),
        .rd_internal_col(rd_icol), .rd_count(rd_count), .addr(addr), .sel_col(sel_col),
        .sel_internal_col(sel_icol), .read_en(read_en), .write_en(write_en),
        .data_out(data_out), .m_data(m_data), .m_index(m_index), .m_last(m_last),
        .m_valid(m_valid), .m_ready(m_ready), .busy(busy), .done(done), .overrun(overrun)
    );

    // AP model, latency 1: mem[i] = i & 8'hff; off-cycle data is deliberately wrong
    logic [9:0] ap1_addr_q = '0;
    logic       ap1_v_q = 1'b0;
    always @(posedge clk) begin
        ap1_v_q    <= read_en;
        ap1_addr_q <= addr;
    end
    assign data_out = ap1_v_q ? ap1_addr_q[7:0] : ~ap1_addr_q[7:0];

    // LAT=3 DUT
    logic       arm3 = 1'b0;
    logic       irq3 = 1'b0;
    logic [9:0] rd_count3 = 10'd4;
    logic       m_ready3 = 1'b1;
    logic [9:0] addr3, m_index3;
    logic [1:0] sel_col3;
    logic       sel_icol3, read_en3, write_en3, m_last3, m_valid3, busy3, done3, overrun3;
    logic [7:0] data_out3, m_data3;

    ap_result_reader #(.WORD_SIZE(8), .CELL_QUANT(512), .ADDR_W(10), .READ_LATENCY(3)) dut3 (
        .CLK100MHZ(clk), .rst(rst), .arm(arm3), .ap_state_irq(irq3), .rd_col(rd_col),
        .rd_internal_col(rd_icol), .rd_count(rd_count3), .addr(addr3), .sel_col(sel_col3),
        .sel_internal_col(sel_icol3), .read_en(read_en3), .write_en(write_en3),
        .data_out(data_out3), .m_data(m_data3), .m_index(m_index3), .m_last(m_last3),
        .m_valid(m_valid3), .m_ready(m_ready3), .busy(busy3), .done(done3),
        .overrun(overrun3)
    );

    logic [9:0] ap3_a [3];
    logic       ap3_v [3];
    initial begin
        for (int i = 0; i < 3; i++) begin
            ap3_a[i] = '0;
            ap3_v[i] = 1'b0;
        end
    end
    always @(posedge clk) begin
        ap3_a[0] <= addr3;
        ap3_v[0] <= read_en3;
        for (int i = 1; i < 3; i++) begin
            ap3_a[i] <= ap3_a[i-1];
            ap3_v[i] <= ap3_v[i-1];
        end
    end
    assign data_out3 = ap3_v[2] ? ap3_a[2][7:0] : ~ap3_a[2][7:0];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int eff_count(input int c);
        return (c == 0 || c > 512) ? 512 : c;
    endfunction

    // Scoreboard state for the LAT=1 DUT
    logic       prev_irq = 1'b0;
    bit         exp_busy = 0, exp_ovr = 0, exp_done = 0, outstanding = 0, stalled = 0;
    int         exp_n = 0, next_read = 0, next_beat = 0, beats_cur = 0, beats_last = 0;
    int         sweeps_acc = 0, sweeps_done = 0, accept_cyc = 0, last_hs_cyc = 0;
    int         last_hs_idx = 0;
    logic [1:0] exp_col = '0;
    logic       exp_icol = 1'b0;
    logic [7:0] held_data = '0, last_hs_data = '0;
    logic [9:0] held_index = '0;
    logic       last_hs_last = 1'b0;

    // Compare process: check this cycle's outputs, then predict what the coming edge does
    always @(negedge clk) begin
        bit nd, irq_edge, busy_now;
        chk("write_en", 32'(write_en), 32'd0);
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("overrun", 32'(overrun), 32'(exp_ovr));
        chk("done", 32'(done), 32'(exp_done));
        if (!exp_busy) begin
            chk("idle_read_en", 32'(read_en), 32'd0);
            chk("idle_addr", 32'(addr), 32'd0);
            chk("idle_sel", 32'({sel_col, sel_icol}), 32'd0);
            chk("idle_m_valid", 32'(m_valid), 32'd0);
        end
        if (read_en) begin
            chk("read_outstanding", 32'(outstanding), 32'd0);
            chk("read_in_present", 32'(m_valid), 32'd0);
            chk("read_addr", 32'(addr), 32'(next_read));
            chk("read_sel_col", 32'(sel_col), 32'(exp_col));
            chk("read_sel_icol", 32'(sel_icol), 32'(exp_icol));
        end
        if (m_valid) begin
            chk("m_index", 32'(m_index), 32'(next_beat));
            chk("m_data", 32'(m_data), 32'(next_beat & 255));
            chk("m_last", 32'(m_last), 32'(next_beat == exp_n - 1));
            if (stalled) begin
                chk("stall_data", 32'(m_data), 32'(held_data));
                chk("stall_index", 32'(m_index), 32'(held_index));
            end
        end
        stalled    = m_valid & ~m_ready;
        held_data  = m_data;
        held_index = m_index;
        if (done) sweeps_done++;
        if (rst) begin
            prev_irq    = 1'b0;
            exp_busy    = 0;
            exp_ovr     = 0;
            exp_done    = 0;
            outstanding = 0;
            stalled     = 0;
            beats_cur   = 0;
        end else begin
            nd = 0;
            if (read_en) begin
                outstanding = 1;
                next_read++;
            end
            if (m_valid && m_ready) begin
                outstanding  = 0;
                last_hs_cyc  = cyc;
                last_hs_idx  = int'(m_index);
                last_hs_data = m_data;
                last_hs_last = m_last;
                beats_cur++;
                if (next_beat == exp_n - 1) nd = 1;
                next_beat++;
            end
            irq_edge = irq & ~prev_irq;
            prev_irq = irq;
            busy_now = exp_busy;
            if (exp_done) begin
                exp_busy   = 0;
                beats_last = beats_cur;
            end
            if (irq_edge && arm) begin
                if (!busy_now) begin
                    exp_busy   = 1;
                    exp_ovr    = 0;
                    exp_n      = eff_count(int'(rd_count));
                    exp_col    = rd_col;
                    exp_icol   = rd_icol;
                    next_read  = 0;
                    next_beat  = 0;
                    beats_cur  = 0;
                    accept_cyc = cyc;
                    sweeps_acc++;
                end else begin
                    exp_ovr = 1;
                end
            end
            exp_done = nd;
        end
    end

    bit ready_mode = 0;
    int ph = 0;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (ready_mode) begin
                m_ready = (ph == 0);
                ph = (ph + 1) % 4;
            end
        end
    endtask

    task automatic wait_done(input int target, input int budget, input string nm);
        int n = 0;
        while (sweeps_done < target && n < budget) begin
            step(1);
            n++;
        end
        chk(nm, 32'(sweeps_done >= target), 32'd1);
    endtask

    task automatic start_sweep(input logic [1:0] col, input logic icol, input logic [9:0] cnt);
        irq = 1'b0;
        step(1);
        rd_col   = col;
        rd_icol  = icol;
        rd_count = cnt;
        irq      = 1'b1;
        step(1);
    endtask

    int hs_cyc [4];
    logic [7:0] hs_data [4];
    logic [9:0] hs_idx [4];
    logic hs_last [4];

    initial begin
        int n, k, acc0, done_cyc, c_acc;
        step(3);
        rst = 1'b0;
        step(1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_m_valid", 32'(m_valid), 32'd0);
        chk("reset_overrun", 32'(overrun), 32'd0);

        // Full column, ready always high
        arm = 1'b1;
        start_sweep(2'd2, 1'b1, 10'd0);
        wait_done(1, 3000, "sweep1_finished");
        chk("sweep1_beats", 32'(beats_last), 32'd512);
        chk("sweep1_last_idx", 32'(last_hs_idx), 32'd511);
        chk("sweep1_last_data", 32'(last_hs_data), 32'hff);
        chk("sweep1_last_flag", 32'(last_hs_last), 32'd1);
        chk("sweep1_latency", 32'(last_hs_cyc - accept_cyc), 32'd1536);
        acc0 = sweeps_acc;
        step(20);
        chk("held_irq_no_restart", 32'(sweeps_acc - acc0), 32'd0);
        chk("held_irq_busy", 32'(busy), 32'd0);

        // Full column with back-pressure
        ready_mode = 1;
        start_sweep(2'd0, 1'b0, 10'd0);
        wait_done(2, 5000, "sweep2_finished");
        ready_mode = 0;
        m_ready = 1'b1;
        chk("sweep2_beats", 32'(beats_last), 32'd512);

        // Short and clamped counts
        start_sweep(2'd1, 1'b0, 10'd3);
        wait_done(3, 100, "sweep3_finished");
        chk("count3_beats", 32'(beats_last), 32'd3);
        chk("count3_last_idx", 32'(last_hs_idx), 32'd2);
        chk("count3_last_data", 32'(last_hs_data), 32'h02);
        chk("count3_last_flag", 32'(last_hs_last), 32'd1);
        start_sweep(2'd2, 1'b1, 10'd600);
        wait_done(4, 3000, "sweep4_finished");
        chk("count600_beats", 32'(beats_last), 32'd512);

        // Overrun: second edge mid-sweep
        start_sweep(2'd0, 1'b1, 10'd0);
        n = 0;
        while (next_beat < 100 && n < 1000) begin
            step(1);
            n++;
        end
        irq = 1'b0;
        step(1);
        irq = 1'b1;
        step(2);
        chk("overrun_set", 32'(overrun), 32'd1);
        wait_done(5, 3000, "sweep5_finished");
        chk("overrun_sweep_beats", 32'(beats_last), 32'd512);
        chk("overrun_sticky", 32'(overrun), 32'd1);
        start_sweep(2'd1, 1'b1, 10'd3);
        step(1);
        chk("overrun_cleared", 32'(overrun), 32'd0);
        chk("overrun_new_busy", 32'(busy), 32'd1);
        wait_done(6, 100, "sweep6_finished");

        // Reset while waiting on the read of index 5
        start_sweep(2'd2, 1'b0, 10'd10);
        n = 0;
        while (!(read_en && addr == 10'd5) && n < 100) begin
            step(1);
            n++;
        end
        chk("reached_read5", 32'(read_en && addr == 10'd5), 32'd1);
        step(1);
        rst = 1'b1;
        irq = 1'b0;
        step(1);
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_read_en", 32'(read_en), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        step(5);
        chk("rst_no_done", 32'(sweeps_done), 32'd6);
        start_sweep(2'd2, 1'b0, 10'd10);
        wait_done(7, 200, "sweep7_finished");
        chk("restart_beats", 32'(beats_last), 32'd10);

        // arm low: edge ignored
        arm = 1'b0;
        acc0 = sweeps_acc;
        start_sweep(2'd1, 1'b1, 10'd4);
        step(10);
        chk("disarmed_busy", 32'(busy), 32'd0);
        chk("disarmed_overrun", 32'(overrun), 32'd0);
        chk("disarmed_no_accept", 32'(sweeps_acc - acc0), 32'd0);
        irq = 1'b0;

        // READ_LATENCY = 3 instance, four words
        arm3 = 1'b1;
        irq3 = 1'b1;
        step(1);
        c_acc = cyc;
        k = 0;
        done_cyc = -1;
        n = 0;
        while (done_cyc < 0 && n < 100) begin
            if (m_valid3 && m_ready3 && k < 4) begin
                hs_cyc[k]  = cyc;
                hs_data[k] = m_data3;
                hs_idx[k]  = m_index3;
                hs_last[k] = m_last3;
                k++;
            end
            if (done3) done_cyc = cyc;
            step(1);
            n++;
        end
        chk("lat3_beats", 32'(k), 32'd4);
        chk("lat3_first_beat", 32'(hs_cyc[0] - c_acc), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("lat3_data", 32'(hs_data[i]), 32'(i));
            chk("lat3_index", 32'(hs_idx[i]), 32'(i));
            chk("lat3_last", 32'(hs_last[i]), 32'(i == 3));
            if (i > 0) chk("lat3_period", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd5);
        end
        chk("lat3_done", 32'(done_cyc - hs_cyc[3]), 32'd1);
        chk("lat3_write_en", 32'(write_en3), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
